// File: rtl/rvr32_glb_arb4.sv
// -----------------------------------------------------------------------------
// rvr32_glb_arb4
//
// Four-port round-robin arbiter and sequencer for the shared global data memory.
// It grants one valid/ready load/store at a time and drives a single-ported,
// whole-word synchronous memory. Stores that write only some bytes of a word
// are executed as read-modify-write sequences.
//
// Ports
//   clk_2x     in   clock, all state on its rising edge
//   rst_n      in   asynchronous active-low reset
//   valid      in   [N_REQ]     per-requester request
//   addr       in   [32*N_REQ]  per-requester byte address (requester i: [32i+31:32i])
//   wstrb      in   [4*N_REQ]   per-requester byte strobes, 0 = read
//   wdata      in   [32*N_REQ]  per-requester write data
//   ready      out  [N_REQ]     one-hot, one-cycle completion pulse
//   rdata      out  [32]        shared read data, valid while ready is high
//   busy       out              high whenever a transaction is in flight
//   grant_id   out  [2]         current or last granted requester
//   mem_ce     out              memory chip enable
//   mem_we     out              memory whole-word write enable
//   mem_addr   out  [32]        word-aligned address of the granted request
//   mem_wdata  out  [32]        word to be written
//   mem_rdata  in   [32]        memory read data, one cycle after a read edge
// -----------------------------------------------------------------------------
module rvr32_glb_arb4 #(
  parameter int N_REQ = 4  // fixed: the grant index is 2 bits wide
) (
  input  logic                 clk_2x,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     valid,
  input  logic [32*N_REQ-1:0]  addr,
  input  logic [4*N_REQ-1:0]   wstrb,
  input  logic [32*N_REQ-1:0]  wdata,
  output logic [N_REQ-1:0]     ready,
  output logic [31:0]          rdata,
  output logic                 busy,
  output logic [1:0]           grant_id,
  output logic                 mem_ce,
  output logic                 mem_we,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_RDATA,
    S_WRITE,
    S_RESP
  } state_t;

  state_t             state_q;
  logic [1:0]         rr_ptr_q;
  logic [1:0]         grant_q;
  logic [3:0]         wstrb_q;
  logic [31:0]        wdata_q;
  logic [N_REQ-1:0]   ready_q;
  logic [31:0]        rdata_q;
  logic               busy_q;
  logic               mem_ce_q;
  logic               mem_we_q;
  logic [31:0]        mem_addr_q;
  logic [31:0]        mem_wdata_q;

  // Round-robin pick: first valid requester at or after rr_ptr, wrapping mod 4.
  logic        pick_vld;
  logic [1:0]  pick_idx;
  logic [1:0]  cand;

  // NOTE: every signal written in always_comb is given a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = rr_ptr_q;
    cand     = rr_ptr_q;
    // Walk from the farthest candidate to the nearest so the nearest wins.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = rr_ptr_q + 2'(k);
      if (valid[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // Payload of the winning requester.
  logic [31:0] pick_addr;
  logic [3:0]  pick_wstrb;
  logic [31:0] pick_wdata;

  assign pick_addr  = addr [32*pick_idx +: 32];
  assign pick_wstrb = wstrb[4*pick_idx  +: 4];
  assign pick_wdata = wdata[32*pick_idx +: 32];

  // Read-modify-write merge: strobed bytes from the store, the rest from memory.
  logic [31:0] merged;

  always_comb begin
    merged = mem_rdata;
    for (int b = 0; b < 4; b++) begin
      if (wstrb_q[b]) merged[8*b +: 8] = wdata_q[8*b +: 8];
    end
  end

  // Each transition loads the outputs of the state being entered, so every
  // output is a register that reflects the current state.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side sees the values from before this edge.
  always_ff @(posedge clk_2x or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= 2'd0;
      grant_q     <= 2'd0;
      wstrb_q     <= 4'd0;
      wdata_q     <= 32'd0;
      ready_q     <= '0;
      rdata_q     <= 32'd0;
      busy_q      <= 1'b0;
      mem_ce_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pick_vld) begin
            grant_q    <= pick_idx;
            wstrb_q    <= pick_wstrb;
            wdata_q    <= pick_wdata;
            mem_addr_q <= {pick_addr[31:2], 2'b00};
            busy_q     <= 1'b1;
            mem_ce_q   <= 1'b1;
            if (pick_wstrb == 4'hF) begin
              // Full-word store skips the read entirely.
              mem_we_q    <= 1'b1;
              mem_wdata_q <= pick_wdata;
              state_q     <= S_WRITE;
            end else begin
              mem_we_q <= 1'b0;
              state_q  <= S_READ;
            end
          end
        end

        S_READ: begin
          mem_ce_q <= 1'b0;
          state_q  <= S_RDATA;
        end

        S_RDATA: begin
          // Partial stores also return the old word.
          rdata_q <= mem_rdata;
          if (wstrb_q == 4'h0) begin
            ready_q <= N_REQ'(1) << grant_q;
            state_q <= S_RESP;
          end else begin
            mem_wdata_q <= merged;
            mem_ce_q    <= 1'b1;
            mem_we_q    <= 1'b1;
            state_q     <= S_WRITE;
          end
        end

        S_WRITE: begin
          mem_ce_q <= 1'b0;
          mem_we_q <= 1'b0;
          ready_q  <= N_REQ'(1) << grant_q;
          state_q  <= S_RESP;
        end

        S_RESP: begin
          ready_q  <= '0;
          busy_q   <= 1'b0;
          rr_ptr_q <= grant_q + 2'd1;
          state_q  <= S_IDLE;
        end

        default: begin
          state_q  <= S_IDLE;
          ready_q  <= '0;
          busy_q   <= 1'b0;
          mem_ce_q <= 1'b0;
          mem_we_q <= 1'b0;
        end
      endcase
    end
  end

  assign ready     = ready_q;
  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign grant_id  = grant_q;
  assign mem_ce    = mem_ce_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
